// File: rtl/xgmii_pla_pkg.sv
// Shared definitions for the XGMII PLA backward-path statistics blocks.
//   XGMII_START / XGMII_TERM : control characters /S/ and /T/
//   snap_state_t             : snapshot handshake FSM states
//   sat_inc8                 : 8-bit saturating increment for run counters
package xgmii_pla_pkg;

  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CAPT = 2'd1,
    S_WAIT = 2'd2
  } snap_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] a);
    return (a == 8'hFF) ? a : a + 8'd1;
  endfunction

endpackage

// File: rtl/xgmii_sat_cnt.sv
// Parametric saturating counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart from zero this cycle (inc still applied on top)
//   inc        : amount to add this cycle
//   cnt        : current count, sticks at all-ones
module xgmii_sat_cnt #(
  parameter int CNT_W = 32,
  parameter int INC_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [INC_W-1:0] inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [INC_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W + 1 - INC_W){1'b0}}, b};
    return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
  endfunction

  // Clear-plus-inc: an event arriving in the clear cycle is kept, not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= sat_add(clr ? {CNT_W{1'b0}} : cnt, inc);
  end

endmodule

// File: rtl/xgmii_crc_err_stat.sv
// CRC verdict statistics for the XGMII PLA backward path.
// Counts good / bad / bad-PTP frames (saturating), raises a consecutive-CRC
// error alarm with set/clear hysteresis, and exposes a coherent shadow copy
// of the counters through a req/ack snapshot handshake.
// Ports:
//   I_312m_clk, I_global_rst           : clock, async active-low reset
//   I_crc_compare_signal, I_crc_ok,
//   I_crc_err, I_ptp_flag              : per-frame verdict, strobe qualified
//   I_xgmii_data, I_xgmii_txc          : XGMII lanes (byte counting only)
//   I_snap_req, I_clr_on_snap          : snapshot request / clear-on-snapshot
//   O_snap_ack                         : one-cycle pulse, shadows valid
//   O_good_cnt, O_bad_cnt,
//   O_ptp_bad_cnt, O_byte_cnt          : shadow counters
//   O_crc_alarm                        : consecutive-error alarm
// Build option: XGMII_CRC_STAT_BYTE_CNT_EN enables in-frame data byte
// counting; otherwise O_byte_cnt is tied to zero.
module xgmii_crc_err_stat
  import xgmii_pla_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int ALM_SET = 8,
  parameter int ALM_CLR = 16
) (
  input  logic             I_312m_clk,
  input  logic             I_global_rst,
  input  logic             I_crc_compare_signal,
  input  logic             I_crc_ok,
  input  logic             I_crc_err,
  input  logic             I_ptp_flag,
  input  logic [31:0]      I_xgmii_data,
  input  logic [3:0]       I_xgmii_txc,
  input  logic             I_snap_req,
  input  logic             I_clr_on_snap,
  output logic             O_snap_ack,
  output logic [CNT_W-1:0] O_good_cnt,
  output logic [CNT_W-1:0] O_bad_cnt,
  output logic [CNT_W-1:0] O_ptp_bad_cnt,
  output logic             O_crc_alarm,
  output logic [CNT_W-1:0] O_byte_cnt
);

  localparam logic [7:0] ALM_SET_B = 8'(ALM_SET);
  localparam logic [7:0] ALM_CLR_B = 8'(ALM_CLR);

  // A strobe with neither ok nor err is treated as a failed compare.
  logic good_v, bad_v;
  assign bad_v  = I_crc_compare_signal & (I_crc_err | ~I_crc_ok);
  assign good_v = I_crc_compare_signal & I_crc_ok & ~I_crc_err;

  snap_state_t state, state_nxt;
  logic        clr_q;
  logic        capt;
  logic        live_clr;

  assign capt     = (state == S_CAPT);
  assign live_clr = capt & clr_q;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (I_snap_req) state_nxt = S_CAPT;
      S_CAPT:  state_nxt = S_WAIT;
      S_WAIT:  if (!I_snap_req) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge I_312m_clk or negedge I_global_rst) begin
    if (!I_global_rst) begin
      state      <= S_IDLE;
      clr_q      <= 1'b0;
      O_snap_ack <= 1'b0;
    end else begin
      state      <= state_nxt;
      O_snap_ack <= capt;
      if (state == S_IDLE && I_snap_req) clr_q <= I_clr_on_snap;
    end
  end

  logic [CNT_W-1:0] good_live, bad_live, ptp_live;

  xgmii_sat_cnt #(.CNT_W(CNT_W), .INC_W(1)) u_good (
    .clk(I_312m_clk), .rst_n(I_global_rst), .clr(live_clr),
    .inc(good_v), .cnt(good_live));

  xgmii_sat_cnt #(.CNT_W(CNT_W), .INC_W(1)) u_bad (
    .clk(I_312m_clk), .rst_n(I_global_rst), .clr(live_clr),
    .inc(bad_v), .cnt(bad_live));

  xgmii_sat_cnt #(.CNT_W(CNT_W), .INC_W(1)) u_ptp_bad (
    .clk(I_312m_clk), .rst_n(I_global_rst), .clr(live_clr),
    .inc(bad_v & I_ptp_flag), .cnt(ptp_live));

  // Shadows take the pre-verdict live value; the verdict of the capture
  // cycle lands in the (possibly cleared) live counter instead.
  always_ff @(posedge I_312m_clk or negedge I_global_rst) begin
    if (!I_global_rst) begin
      O_good_cnt    <= '0;
      O_bad_cnt     <= '0;
      O_ptp_bad_cnt <= '0;
    end else if (capt) begin
      O_good_cnt    <= good_live;
      O_bad_cnt     <= bad_live;
      O_ptp_bad_cnt <= ptp_live;
    end
  end

  // Run counters and alarm are independent of the snapshot clear.
  logic [7:0] bad_run, good_run;

  always_ff @(posedge I_312m_clk or negedge I_global_rst) begin
    if (!I_global_rst) begin
      bad_run     <= '0;
      good_run    <= '0;
      O_crc_alarm <= 1'b0;
    end else begin
      if (bad_v) begin
        bad_run  <= sat_inc8(bad_run);
        good_run <= '0;
      end else if (good_v) begin
        good_run <= sat_inc8(good_run);
        bad_run  <= '0;
      end
      if (!O_crc_alarm && bad_run >= ALM_SET_B)     O_crc_alarm <= 1'b1;
      else if (O_crc_alarm && good_run >= ALM_CLR_B) O_crc_alarm <= 1'b0;
    end
  end

`ifdef XGMII_CRC_STAT_BYTE_CNT_EN
  logic             in_frame;
  logic             sof, eof;
  logic [2:0]       lanes;
  logic [CNT_W-1:0] byte_live;

  assign sof = I_xgmii_txc[0] && (I_xgmii_data[7:0] == XGMII_START);

  always_comb begin
    eof = 1'b0;
    for (int i = 0; i < 4; i++)
      if (I_xgmii_txc[i] && (I_xgmii_data[8*i +: 8] == XGMII_TERM)) eof = 1'b1;
  end

  // The /S/ cycle and the /T/ cycle both count their data lanes.
  always_comb begin
    lanes = 3'd0;
    if (in_frame || sof)
      for (int i = 0; i < 4; i++)
        if (!I_xgmii_txc[i]) lanes = lanes + 3'd1;
  end

  always_ff @(posedge I_312m_clk or negedge I_global_rst) begin
    if (!I_global_rst) in_frame <= 1'b0;
    else if (sof)      in_frame <= 1'b1;
    else if (eof)      in_frame <= 1'b0;
  end

  xgmii_sat_cnt #(.CNT_W(CNT_W), .INC_W(3)) u_byte (
    .clk(I_312m_clk), .rst_n(I_global_rst), .clr(live_clr),
    .inc(lanes), .cnt(byte_live));

  always_ff @(posedge I_312m_clk or negedge I_global_rst) begin
    if (!I_global_rst) O_byte_cnt <= '0;
    else if (capt)     O_byte_cnt <= byte_live;
  end
`else
  logic unused_xgmii;
  assign unused_xgmii = ^{I_xgmii_data, I_xgmii_txc};
  assign O_byte_cnt   = '0;
`endif

endmodule

// File: tb/tb_xgmii_crc_err_stat.sv
module tb_xgmii_crc_err_stat;
  import xgmii_pla_pkg::*;

  localparam int CNT_W = 8;
  localparam int CMAX  = 255;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             stb_i = 1'b0, ok_i = 1'b0, err_i = 1'b0, ptp_i = 1'b0;
  logic [31:0]      xd = 32'h07070707;
  logic [3:0]       xc = 4'hF;
  logic             req_i = 1'b0, clr_i = 1'b0;
  logic             ack_o, alarm_o;
  logic [CNT_W-1:0] good_o, bad_o, ptp_o, byte_o;

  always #5 clk = ~clk;

  xgmii_crc_err_stat #(.CNT_W(CNT_W), .ALM_SET(8), .ALM_CLR(16)) dut (
    .I_312m_clk(clk), .I_global_rst(rst_n),
    .I_crc_compare_signal(stb_i), .I_crc_ok(ok_i), .I_crc_err(err_i),
    .I_ptp_flag(ptp_i), .I_xgmii_data(xd), .I_xgmii_txc(xc),
    .I_snap_req(req_i), .I_clr_on_snap(clr_i),
    .O_snap_ack(ack_o), .O_good_cnt(good_o), .O_bad_cnt(bad_o),
    .O_ptp_bad_cnt(ptp_o), .O_crc_alarm(alarm_o), .O_byte_cnt(byte_o));

  int n_vec = 0;
  int n_err = 0;

  // Reference model: live counts, shadows, consecutive-run lengths, alarm.
  int m_good, m_bad, m_ptp, s_good, s_bad, s_ptp, m_brun, m_grun;
  bit m_alarm;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_good = 0; m_bad = 0; m_ptp = 0;
    s_good = 0; s_bad = 0; s_ptp = 0;
    m_brun = 0; m_grun = 0; m_alarm = 0;
  endtask

  // One clock with the given inputs; cap marks the edge where the snapshot
  // is taken (second edge with req high after idle).
  task automatic step(input bit stb, input bit ok, input bit err, input bit ptp,
                      input bit req, input bit clr, input bit cap);
    bit bad, good;
    stb_i = stb; ok_i = ok; err_i = err; ptp_i = ptp;
    req_i = req; clr_i = clr;
    @(posedge clk); #1;
    bad  = stb && (err || !ok);
    good = stb && !bad;
    if (!m_alarm && m_brun >= 8)       m_alarm = 1;
    else if (m_alarm && m_grun >= 16)  m_alarm = 0;
    if (bad)       begin m_brun = sat(m_brun + 1, 255); m_grun = 0; end
    else if (good) begin m_grun = sat(m_grun + 1, 255); m_brun = 0; end
    if (cap) begin
      s_good = m_good; s_bad = m_bad; s_ptp = m_ptp;
      if (clr) begin m_good = 0; m_bad = 0; m_ptp = 0; end
    end
    m_good = sat(m_good + int'(good), CMAX);
    m_bad  = sat(m_bad + int'(bad), CMAX);
    m_ptp  = sat(m_ptp + int'(bad && ptp), CMAX);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic snapshot(input bit clr, input bit stb, input bit ok,
                          input bit err, input bit ptp);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, clr, 1'b0);
    step(stb, ok, err, ptp, 1'b1, clr, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec += 6;
    if (ack_o !== 1'b0)   begin n_err++; $display("FAIL reset_ack: got %b want 0", ack_o); end
    if (alarm_o !== 1'b0) begin n_err++; $display("FAIL reset_alarm: got %b want 0", alarm_o); end
    if (good_o !== '0)    begin n_err++; $display("FAIL reset_good: got %0d want 0", good_o); end
    if (bad_o !== '0)     begin n_err++; $display("FAIL reset_bad: got %0d want 0", bad_o); end
    if (ptp_o !== '0)     begin n_err++; $display("FAIL reset_ptp: got %0d want 0", ptp_o); end
    if (byte_o !== '0)    begin n_err++; $display("FAIL reset_byte: got %0d want 0", byte_o); end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_good_count();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0);
      idle($urandom_range(0, 2));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    n_vec++;
    if (ack_o !== 1'b0) begin n_err++; $display("FAIL ack_early: got %b want 0", ack_o); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    n_vec += 4;
    if (ack_o !== 1'b1) begin n_err++; $display("FAIL ack_latency2: got %b want 1", ack_o); end
    if (good_o !== 8'd5) begin n_err++; $display("FAIL good5: got %0d want 5", good_o); end
    if (bad_o !== 8'd0)  begin n_err++; $display("FAIL good5_bad: got %0d want 0", bad_o); end
    if (ptp_o !== 8'd0)  begin n_err++; $display("FAIL good5_ptp: got %0d want 0", ptp_o); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (ack_o !== 1'b0) begin n_err++; $display("FAIL ack_pulse: got %b want 0", ack_o); end
  endtask

  task automatic test_bad_ptp();
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    snapshot(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_vec += 3;
    if (bad_o !== 8'd4)  begin n_err++; $display("FAIL bad4: got %0d want 4", bad_o); end
    if (ptp_o !== 8'd1)  begin n_err++; $display("FAIL ptp1: got %0d want 1", ptp_o); end
    if (good_o !== 8'd0) begin n_err++; $display("FAIL bad4_good: got %0d want 0", good_o); end
  endtask

  task automatic test_alarm();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
    idle(2);
    n_vec++;
    if (alarm_o !== 1'b0) begin n_err++; $display("FAIL alarm_7bad: got %b want 0", alarm_o); end
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    n_vec++;
    if (alarm_o !== 1'b1) begin n_err++; $display("FAIL alarm_8bad: got %b want 1", alarm_o); end
    for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    n_vec++;
    if (alarm_o !== 1'b1) begin n_err++; $display("FAIL alarm_15good: got %b want 1", alarm_o); end
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    n_vec++;
    if (alarm_o !== 1'b0) begin n_err++; $display("FAIL alarm_16good: got %b want 0", alarm_o); end
  endtask

  task automatic test_snap_clear();
    snapshot(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    snapshot(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    n_vec += 2;
    if (bad_o !== 8'd9)   begin n_err++; $display("FAIL snapclr_shadow: got %0d want 9", bad_o); end
    if (alarm_o !== 1'b1) begin n_err++; $display("FAIL snapclr_alarm: got %b want 1", alarm_o); end
    snapshot(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_vec += 2;
    if (bad_o !== 8'd1)     begin n_err++; $display("FAIL snapclr_live: got %0d want 1", bad_o); end
    if (bad_o !== 8'(s_bad)) begin n_err++; $display("FAIL snapclr_model: got %0d want %0d", bad_o, s_bad); end
  endtask

  task automatic test_saturation();
    snapshot(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    snapshot(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_vec += 2;
    if (good_o !== 8'd255) begin n_err++; $display("FAIL sat_good: got %0d want 255", good_o); end
    if (alarm_o !== 1'b0)  begin n_err++; $display("FAIL sat_alarm: got %b want 0", alarm_o); end
  endtask

  task automatic test_hold_req();
    int acks;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, (i == 1));
      if (ack_o === 1'b1) acks++;
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (ack_o === 1'b1) acks++;
    n_vec++;
    if (acks != 1) begin n_err++; $display("FAIL hold_one_ack: got %0d want 1", acks); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit stb, ok, err, burst;
      burst = ((i / 50) % 2) == 1;
      stb = ($urandom_range(0, 3) != 0);
      if (burst) begin ok = ($urandom_range(0, 9) == 0); err = !ok && ($urandom_range(0, 3) != 0); end
      else begin ok = ($urandom_range(0, 19) != 0); err = ($urandom_range(0, 29) == 0); end
      if (i % 37 == 36) begin
        snapshot(1'($urandom), stb, ok, err, 1'($urandom));
        n_vec += 3;
        if (good_o !== 8'(s_good)) begin n_err++; $display("FAIL rnd_good@%0d: got %0d want %0d", i, good_o, s_good); end
        if (bad_o !== 8'(s_bad))   begin n_err++; $display("FAIL rnd_bad@%0d: got %0d want %0d", i, bad_o, s_bad); end
        if (ptp_o !== 8'(s_ptp))   begin n_err++; $display("FAIL rnd_ptp@%0d: got %0d want %0d", i, ptp_o, s_ptp); end
      end else begin
        step(stb, ok, err, 1'($urandom), 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (alarm_o !== m_alarm) begin n_err++; $display("FAIL rnd_alarm@%0d: got %b want %b", i, alarm_o, m_alarm); end
      end
    end
  endtask

  task automatic send_frame(input int n_mid, input int term_lane);
    xd = {8'($urandom), 8'($urandom), 8'($urandom), XGMII_START};
    xc = 4'b0001;
    idle(1);
    for (int i = 0; i < n_mid; i++) begin
      xd = $urandom; xc = 4'b0000;
      idle(1);
    end
    xd = $urandom; xc = 4'b0000;
    for (int l = 0; l < 4; l++) begin
      if (l == term_lane) begin xd[8*l +: 8] = XGMII_TERM; xc[l] = 1'b1; end
      else if (l > term_lane) begin xd[8*l +: 8] = 8'h07; xc[l] = 1'b1; end
    end
    idle(1);
    xd = 32'h07070707; xc = 4'hF;
    idle(2);
  endtask

  task automatic test_byte_cnt();
    int exp_b, n, k;
    snapshot(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    send_frame(15, 2);
    snapshot(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef XGMII_CRC_STAT_BYTE_CNT_EN
    exp_b = 65;
`else
    exp_b = 0;
`endif
    n_vec++;
    if (byte_o !== 8'(exp_b)) begin n_err++; $display("FAIL byte_frame: got %0d want %0d", byte_o, exp_b); end
    n = $urandom_range(0, 20);
    k = $urandom_range(0, 3);
    send_frame(n, k);
    snapshot(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef XGMII_CRC_STAT_BYTE_CNT_EN
    exp_b = sat(65 + 3 + 4 * n + k, CMAX);
`endif
    n_vec++;
    if (byte_o !== 8'(exp_b)) begin n_err++; $display("FAIL byte_rand: got %0d want %0d", byte_o, exp_b); end
  endtask

  task automatic test_reset_mid();
    xd = {24'h555555, XGMII_START}; xc = 4'b0001;
    idle(1);
    xd = $urandom; xc = 4'b0000;
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    model_reset();
    n_vec += 6;
    if (ack_o !== 1'b0)   begin n_err++; $display("FAIL rstmid_ack: got %b want 0", ack_o); end
    if (alarm_o !== 1'b0) begin n_err++; $display("FAIL rstmid_alarm: got %b want 0", alarm_o); end
    if (good_o !== '0)    begin n_err++; $display("FAIL rstmid_good: got %0d want 0", good_o); end
    if (bad_o !== '0)     begin n_err++; $display("FAIL rstmid_bad: got %0d want 0", bad_o); end
    if (ptp_o !== '0)     begin n_err++; $display("FAIL rstmid_ptp: got %0d want 0", ptp_o); end
    if (byte_o !== '0)    begin n_err++; $display("FAIL rstmid_byte: got %0d want 0", byte_o); end
    @(posedge clk); #1;
    req_i = 1'b0; stb_i = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      xd = $urandom; xc = 4'b0000;
      idle(1);
      n_vec++;
      if (ack_o !== 1'b0) begin n_err++; $display("FAIL rstmid_noack%0d: got %b want 0", i, ack_o); end
    end
    xd = {8'h07, 8'h07, XGMII_TERM, 8'h12}; xc = 4'b1110;
    idle(1);
    xd = 32'h07070707; xc = 4'hF;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    n_vec += 3;
    if (ack_o !== 1'b1)  begin n_err++; $display("FAIL rstmid_snap_ack: got %b want 1", ack_o); end
    if (byte_o !== '0)   begin n_err++; $display("FAIL rstmid_byte_after: got %0d want 0", byte_o); end
    if (good_o !== '0)   begin n_err++; $display("FAIL rstmid_good_after: got %0d want 0", good_o); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_good_count();
    test_bad_ptp();
    test_alarm();
    test_snap_clear();
    test_saturation();
    test_hold_req();
    test_random();
    test_byte_cnt();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/xgmii_crc_err_stat.md
Name: xgmii_crc_err_stat

Overview:
- Downstream consumer of the 32-bit XGMII CRC compare stage in the PLA backward path.
- Takes that stage's per-frame verdict (compare strobe plus ok/err) and the PTP flag, and keeps saturating good/bad frame counters.
- Drives a consecutive-CRC-error alarm with hysteresis.
- Provides a snapshot/clear handshake so the register/CPU side gets a coherent counter set.

Parameters:
- CNT_W, 32: width of every frame counter.
- ALM_SET, 8: consecutive bad frames that raise the alarm (1..255).
- ALM_CLR, 16: consecutive good frames that clear the alarm (1..255).

Ports:
- I_312m_clk  in  1  system clock, 312.5 MHz.
- I_global_rst  in  1  asynchronous reset, active-low.
- I_crc_compare_signal  in  1  one-cycle strobe; a frame verdict is valid this cycle.
- I_crc_ok  in  1  CRC matched; qualified by the strobe.
- I_crc_err  in  1  CRC mismatched; qualified by the strobe.
- I_ptp_flag  in  1  current frame is PTP; qualified by the strobe.
- I_xgmii_data  in  32  XGMII lanes; used only by the optional feature.
- I_xgmii_txc  in  4  XGMII control bits; used only by the optional feature.
- I_snap_req  in  1  level request: snapshot the counters.
- I_clr_on_snap  in  1  clear live counters at the snapshot; sampled with I_snap_req.
- O_snap_ack  out  1  one-cycle pulse; shadow counters are valid.
- O_good_cnt  out  CNT_W  shadow good-frame count.
- O_bad_cnt  out  CNT_W  shadow bad-frame count.
- O_ptp_bad_cnt  out  CNT_W  shadow bad-PTP-frame count.
- O_crc_alarm  out  1  consecutive-error alarm.
- O_byte_cnt  out  CNT_W  shadow data-byte count; 0 when the feature is absent.

Behaviour:
- Reset (asynchronous assert, synchronous release): all live counters, shadows, run counters, O_snap_ack and O_crc_alarm go to 0; FSM goes to S_IDLE.
- Verdict decode, only when I_crc_compare_signal=1:
  - err=1 → bad, regardless of ok.
  - ok=1, err=0 → good.
  - ok=0, err=0 → bad; a strobe without a verdict is an error.
  - Any ok/err with strobe=0 is ignored.
- Counters: a good verdict increments good_cnt; a bad verdict increments bad_cnt, and also ptp_bad_cnt when I_ptp_flag=1. Each is live next cycle and saturates at 2^CNT_W-1 with no wrap.
- Alarm run counters (8 bit, saturating at 255):
  - bad_run: +1 on bad, reset to 0 on good.
  - good_run: +1 on good, reset to 0 on bad.
  - O_crc_alarm rises the cycle after bad_run reaches ALM_SET.
  - O_crc_alarm falls the cycle after good_run reaches ALM_CLR while the alarm is set.
- Snapshot FSM:
  - S_IDLE → S_CAPT on I_snap_req=1.
  - S_CAPT: copy live counters to the shadows; if I_clr_on_snap is set, zero the live counters. O_snap_ack=1 for one cycle. Go to S_WAIT.
  - S_WAIT: stay until I_snap_req=0, then return to S_IDLE. Holding req high gives exactly one ack.
  - Latency from req rising to ack is 2 cycles.
  - Shadows hold their value until the next capture.
- Simultaneous verdict and capture: the shadow takes the pre-verdict value. The live counter becomes 1 if cleared, otherwise old+1. No event is ever lost.
- Alarm and run counters are never affected by a snapshot clear.
- If reset asserts mid-handshake, the FSM returns to S_IDLE and no ack is issued.

Optional Feature:
- XGMII_CRC_STAT_BYTE_CNT_EN defined:
  - In-frame flag sets when lane0 is /S/ (txc[0]=1, data[7:0]=8'hFB).
  - The flag clears on any lane carrying /T/ (8'hFD with its txc bit set).
  - While in frame, add the number of lanes with txc=0 to the live byte counter: 0..4 per cycle, saturating. The start cycle contributes 3.
  - Byte counter is snapshotted and cleared like the other counters.
- Undefined: O_byte_cnt is tied to 0 and no frame-tracking logic exists.

Decomposition:
- Shared package xgmii_pla_pkg holds:
  - XGMII_START=8'hFB, XGMII_TERM=8'hFD.
  - Snapshot FSM state encoding (S_IDLE, S_CAPT, S_WAIT).
  - A saturating-add helper function.
- One natural sub-module: xgmii_sat_cnt, a parametric width saturating counter with inc amount, clear and clear-plus-inc; instantiated once per counter.

Test Plan:
- Good-frame count: 5 strobes with ok=1 → req → ack 2 cycles later; good=5, bad=0, ptp_bad=0.
- Bad-frame and PTP count: 3 strobes with err=1 (one with ptp=1), then 1 strobe with ok=0/err=0 → bad=4, ptp_bad=1.
- Alarm hysteresis (ALM_SET=8, ALM_CLR=16):
  - 8 consecutive errors → alarm=1 the cycle after the 8th.
  - 15 good frames → alarm still 1.
  - 16th good frame → alarm=0.
- Snapshot with clear: I_clr_on_snap=1 and a bad strobe in the capture cycle with bad=9 → shadow bad=9; next snapshot shows bad=1.
- Saturation: CNT_W=4 with 20 good strobes → good=15. Req held 10 cycles → exactly one ack pulse.
- With XGMII_CRC_STAT_BYTE_CNT_EN:
  - Frame /S/+3B, 15×4B, 2B+/T/ → byte_cnt=65.
  - Reset asserted mid-frame → all outputs 0, FSM in S_IDLE.
